// File: rtl/pmod_audio_dac_if.sv
// Sample handshake between the APU mixer and the PMOD audio DAC.
// Carries one sample word per channel.
interface pmod_audio_dac_if #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 16
);
    logic [CHANNELS*SAMPLE_W-1:0] sample_in;
    logic                         sample_valid;
    logic                         sample_ready;

    modport master (output sample_in, output sample_valid, input sample_ready);
    modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/pmod_audio_dac.sv
// Multi-channel PWM / first-order sigma-delta DAC for the PAM8403 PMOD.
// A one-deep holding register feeds per-channel active levels at each period boundary.
module pmod_audio_dac_lane #(
    parameter int SAMPLE_W  = 16,
    parameter int PWM_BITS  = 9,
    parameter int SIGNED_IN = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                clr_i,
    input  logic                mode_i,
    input  logic [SAMPLE_W-1:0] smp_i,
    input  logic [2:0]          vol_i,
    input  logic                mute_i,
    input  logic [PWM_BITS-1:0] cnt_i,
    output logic                out_o
);
    logic [SAMPLE_W-1:0] u, a, act_q, acc_q, acc_d;
    logic [SAMPLE_W:0]   sum;
    logic                out_q, out_d;

    always_comb begin
        u = smp_i;
        if (SIGNED_IN != 0) u[SAMPLE_W-1] = ~smp_i[SAMPLE_W-1];
        a = u >> vol_i;
        if (mute_i) a = (SIGNED_IN != 0) ? {1'b1, {(SAMPLE_W-1){1'b0}}} : '0;
        // the accumulator keeps only the low bits; the carry goes straight to the output
        sum   = {1'b0, acc_q} + {1'b0, act_q};
        acc_d = clr_i ? '0 : sum[SAMPLE_W-1:0];
        out_d = mode_i ? sum[SAMPLE_W] : (cnt_i < act_q[SAMPLE_W-1 -: PWM_BITS]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q <= '0;
            acc_q <= '0;
            out_q <= 1'b0;
        end else begin
            if (load_i) act_q <= a;
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign out_o = out_q;
endmodule

module pmod_audio_dac #(
    parameter int CHANNELS  = 2,
    parameter int SAMPLE_W  = 16,
    parameter int PWM_BITS  = 9,
    parameter int SIGNED_IN = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    pmod_audio_dac_if.slave      smp,
    input  logic                 mode,
    input  logic [2:0]           volume,
    input  logic                 mute,
    output logic                 period_start,
    output logic                 underrun,
    output logic [7:0]           output_pmod
);
    logic [PWM_BITS-1:0]          cnt_q, cnt_d;
    logic [CHANNELS*SAMPLE_W-1:0] hold_q, hold_d;
    logic                         full_q, full_d;
    logic                         first_q, mode_q, ps_q, ur_q;
    logic                         bnd, xfer;
    logic [CHANNELS-1:0]          out_w;

    // the counter==0 cycle right after reset release is not a boundary
    assign bnd  = (cnt_q == '0) && !first_q;
    assign xfer = smp.sample_valid && !full_q;
    assign smp.sample_ready = !full_q;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        hold_d = hold_q;
        full_d = full_q;
        if (bnd) full_d = 1'b0;
        if (xfer) begin
            hold_d = smp.sample_in;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            first_q <= 1'b1;
            mode_q  <= 1'b0;
            ps_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            first_q <= 1'b0;
            if (bnd) mode_q <= mode;
            ps_q    <= bnd;
            ur_q    <= bnd && !full_q;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        pmod_audio_dac_lane #(
            .SAMPLE_W (SAMPLE_W),
            .PWM_BITS (PWM_BITS),
            .SIGNED_IN(SIGNED_IN)
        ) u_lane (
            .clk   (clk),
            .rst   (reset),
            .load_i(bnd && full_q),
            .clr_i (bnd && (mode != mode_q)),
            .mode_i(mode_q),
            .smp_i (hold_q[c*SAMPLE_W +: SAMPLE_W]),
            .vol_i (volume),
            .mute_i(mute),
            .cnt_i (cnt_q),
            .out_o (out_w[c])
        );
    end

    always_comb begin
        output_pmod = '0;
        output_pmod[CHANNELS-1:0] = out_w;
    end

    assign period_start = ps_q;
    assign underrun     = ur_q;
endmodule

// File: doc/pmod_audio_dac.md
Name: pmod_audio_dac

Overview:
- Multi-channel, parametrised PWM / first-order sigma-delta audio DAC driving the PAM8403 PMOD audio module. Clocked at 21.477 MHz.
- Sits between the APU mixer and the PMOD pins.
- Successor to the fixed 16-bit, single-level PWM output. Adds:
  - per-channel samples;
  - a valid/ready sample handshake with a one-deep holding register;
  - signed input;
  - volume attenuation and mute;
  - selectable sigma-delta mode;
  - underrun reporting.

Parameters:
- CHANNELS, 2, number of output channels (1..8); channel c drives output_pmod[c].
- SAMPLE_W, 16, sample width per channel (>= PWM_BITS).
- PWM_BITS, 9, PWM period is 2^PWM_BITS clocks (512 gives 42 kHz at 21.477 MHz).
- SIGNED_IN, 0, 1 means samples are two's complement.

Ports:
- clk  in  1  system clock, 21.477 MHz
- reset  in  1  asynchronous, active-high reset
- sample_in  in  CHANNELS*SAMPLE_W  channel c at [c*SAMPLE_W +: SAMPLE_W]
- sample_valid  in  1  sample_in is valid
- sample_ready  out  1  holding register empty; transfer occurs when valid and ready are both high
- mode  in  1  0 = PWM, 1 = sigma-delta
- volume  in  3  attenuation as a right shift (0..7)
- mute  in  1  forces silence level
- period_start  out  1  one-cycle pulse at each period start
- underrun  out  1  one-cycle pulse when a period starts with no new sample
- output_pmod  out  8  bit c = channel c audio; bits CHANNELS..7 driven 0

Behaviour:
- Reset (async assert, sync release). The following are cleared:
  - counter = 0;
  - holding empty;
  - active levels = 0;
  - sigma-delta accumulators = 0;
  - output_pmod = 0, period_start = 0, underrun = 0.
- sample_ready = ~holding_full, so it reads 1 during and after reset.
- Counter: PWM_BITS wide, free-running, increments every clk, wraps 2^PWM_BITS-1 -> 0.
- Handshake:
  - valid && ready loads all channels into the holding register and sets holding_full.
  - sample_in is not held stable by the source after the transfer.
- Boundary (counter == 0):
  - If holding is full: the active levels load processed(holding) and holding empties.
  - If holding is empty: active levels are kept (the last sample repeats) and underrun pulses on the next cycle.
  - mode, volume and mute are sampled only at the boundary.
  - A boundary cycle that is also a handshake transfer cycle: the new sample goes to holding only (no bypass), and underrun still pulses.
- period_start is registered and high for the single cycle where counter == 1, i.e. the cycle the new active levels first take effect.
- Processing, per channel, sample s:
  - u = SIGNED_IN ? {~s[MSB], s[MSB-1:0]} : s (offset binary).
  - a = u >> volume.
  - If mute: a = SIGNED_IN ? 2^(SAMPLE_W-1) : 0.
  - level L = a[SAMPLE_W-1 -: PWM_BITS]; the sigma-delta path uses the full a.
- PWM mode:
  - out_c registered as (counter < L); one clk latency.
  - High count per period = L exactly. L = 0 gives constant 0; L max gives 2^PWM_BITS-1 high clocks.
  - There is no forced-high slot at counter 0.
- Sigma-delta mode:
  - acc_c is SAMPLE_W+1 bits.
  - Each clk: acc_c <= {1'b0, acc_c[SAMPLE_W-1:0]} + a; out_c <= the carry (bit SAMPLE_W) of that sum.
  - Mean density = a / 2^SAMPLE_W.
  - Accumulators clear at any boundary where the latched mode changes.
- A mode change mid-period has no effect until the next boundary.
- Reset mid-period: outputs go 0 immediately; after release, the first boundary occurs 2^PWM_BITS clocks later, counting from counter = 0 at release.

Test Plan:
- Defaults, PWM mode, unsigned, volume 0, sample 0x8000 per channel, accepted before first wrap -> from the period after the boundary, exactly 256 of 512 clocks high on both output_pmod[1:0]; bits 7..2 stay 0; period_start once every 512 clocks.
- PWM mode, sample 0x0000 -> output constant 0. Sample 0xFFFF -> 511 high per period. 0xFFFF with volume 1 -> 255 high.
- SIGNED_IN=1: sample 0x0000 -> 256 high. 0x8000 -> 0 high. mute=1 with 0x7FFF -> 256 high. Changing mute mid-period takes effect only at the next boundary.
- Sigma-delta mode, sample 0x4000 -> after the boundary, output high on every 4th clk, 128 per 512 clocks. Switching back to PWM at the next boundary -> duty 128/512 and accumulators cleared.
- Two samples offered back-to-back -> first accepted and sample_ready drops; second is stalled until the cycle after the boundary, then accepted. No new sample for two periods -> underrun pulses twice and the previous level repeats.
- Assert reset mid-period with output high -> output_pmod = 0 and sample_ready = 1 immediately. After release, underrun at the first boundary with level 0.
